// File: rtl/cone_feeder_pkg.sv
// Shared constants, FSM state type and MISR step function for the cone vector feeder.
package cone_feeder_pkg;

   localparam int unsigned CONE_W   = 36;
   localparam int unsigned SIG_W    = 16;
   localparam int unsigned SETTLE_W = 4;
   localparam logic [SIG_W-1:0] SIG_POLY = 16'h1021;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HOLD   = 2'd2
   } feeder_state_e;

   // One MISR shift: feedback is the outgoing MSB xor the captured bit.
   function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] s, input logic b);
      return {s[SIG_W-2:0], 1'b0} ^ ((s[SIG_W-1] ^ b) ? SIG_POLY : SIG_W'(0));
   endfunction

endpackage

// File: rtl/cone_sig_misr.sv
// 16-bit result signature register; clear has priority over a capture.
module cone_sig_misr
   import cone_feeder_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_capture,
   input  logic             i_bit,
   input  logic             i_clr,
   output logic [SIG_W-1:0] o_sig
);

   logic [SIG_W-1:0] r_sig;

   always_ff @(posedge clk) begin
      if (!rst_n || i_clr) begin
         r_sig <= '0;
      end else if (i_capture) begin
         r_sig <= misr_next(r_sig, i_bit);
      end
   end

   assign o_sig = r_sig;

endmodule

// File: rtl/cone_vector_feeder.sv
// Applies 36-bit vectors to a combinational cone, waits SETTLE_CYCLES, captures the result.
// Optional result signature MISR enabled by defining CONE_SIG_EN.
module cone_vector_feeder
   import cone_feeder_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned CNT_W         = 16
) (
   input  logic              clk,
   input  logic              rst_n,
`ifdef CONE_SIG_EN
   output logic [SIG_W-1:0]  sig,
   input  logic              sig_clr,
`endif
   input  logic              vec_valid,
   input  logic [CONE_W-1:0] vec_data,
   output logic              vec_ready,
   output logic [CONE_W-1:0] cone_in,
   input  logic              cone_out,
   output logic              res_valid,
   output logic              res_data,
   input  logic              res_ready,
   output logic [CNT_W-1:0]  vec_cnt
);

   feeder_state_e       r_state;
   logic [SETTLE_W-1:0] r_settle_cnt;
   logic [CONE_W-1:0]   r_cone_in;
   logic                r_res_valid;
   logic                r_res_data;
   logic [CNT_W-1:0]    r_vec_cnt;
   logic                w_capture;

   assign w_capture = (r_state == SETTLE) && (r_settle_cnt == SETTLE_W'(1));

   // Ready is gated by reset so upstream never handshakes while the feeder is being cleared.
   assign vec_ready = rst_n && (r_state == IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_settle_cnt <= '0;
         r_cone_in    <= '0;
         r_res_valid  <= 1'b0;
         r_res_data   <= 1'b0;
         r_vec_cnt    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (vec_valid) begin
                  r_cone_in    <= vec_data;
                  r_settle_cnt <= SETTLE_W'(SETTLE_CYCLES);
                  r_state      <= SETTLE;
               end
            end
            SETTLE: begin
               r_settle_cnt <= r_settle_cnt - SETTLE_W'(1);
               if (w_capture) begin
                  r_res_data  <= cone_out;
                  r_res_valid <= 1'b1;
                  r_state     <= HOLD;
               end
            end
            HOLD: begin
               if (res_ready) begin
                  r_res_valid <= 1'b0;
                  r_vec_cnt   <= r_vec_cnt + CNT_W'(1);
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign cone_in   = r_cone_in;
   assign res_valid = r_res_valid;
   assign res_data  = r_res_data;
   assign vec_cnt   = r_vec_cnt;

`ifdef CONE_SIG_EN
   cone_sig_misr u_misr (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_capture (w_capture),
      .i_bit     (cone_out),
      .i_clr     (sig_clr),
      .o_sig     (sig)
   );
`endif

endmodule

// File: tb/tb_cone_vector_feeder.sv
// Randomized and directed bench for cone_vector_feeder against a transaction-level model.
module tb_cone_vector_feeder;

   localparam int unsigned S  = 2;
   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          vec_valid;
   logic [35:0]   vec_data;
   logic          vec_ready;
   logic [35:0]   cone_in;
   logic          cone_out;
   logic          res_valid;
   logic          res_data;
   logic          res_ready;
   logic [CW-1:0] vec_cnt;
   logic          force_en;
   logic          force_val;
`ifdef CONE_SIG_EN
   logic [15:0]   sig;
   logic          sig_clr;
   logic [15:0]   m_sig;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // Transaction model: busy from accept to result handshake, result appears S edges after accept.
   bit          m_busy;
   bit          m_res;
   bit          m_res_data;
   logic [35:0] m_cone;
   int          m_acc_edge;
   int          m_cnt;
   int          m_done;
   int          edge_n;

   always #5 clk = ~clk;

   // Stand-in cone: parity of the inputs, optionally overridden.
   assign cone_out = force_en ? force_val : ^cone_in;

   cone_vector_feeder #(.SETTLE_CYCLES(S), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef CONE_SIG_EN
      .sig       (sig),
      .sig_clr   (sig_clr),
`endif
      .vec_valid (vec_valid),
      .vec_data  (vec_data),
      .vec_ready (vec_ready),
      .cone_in   (cone_in),
      .cone_out  (cone_out),
      .res_valid (res_valid),
      .res_data  (res_data),
      .res_ready (res_ready),
      .vec_cnt   (vec_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

`ifdef CONE_SIG_EN
   function automatic logic [15:0] ref_misr(input logic [15:0] s, input logic b);
      logic fb;
      fb = s[15] ^ b;
      return {s[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
   endfunction
`endif

   // One clock: predict from pre-edge inputs, advance model, check DUT just after the edge.
   task automatic step();
      bit   acc, cap, hs;
      logic co;
      co  = force_en ? force_val : ^m_cone;
      acc = rst_n && !m_busy && vec_valid;
      cap = rst_n && m_busy && !m_res && (edge_n + 1 == m_acc_edge + int'(S));
      hs  = rst_n && m_res && res_ready;
      @(posedge clk);
      edge_n++;
      if (!rst_n) begin
         m_busy = 0; m_res = 0; m_res_data = 0; m_cone = '0; m_cnt = 0;
`ifdef CONE_SIG_EN
         m_sig = '0;
`endif
      end else begin
         if (acc) begin
            m_busy = 1; m_cone = vec_data; m_acc_edge = edge_n;
         end
         if (cap) begin
            m_res = 1; m_res_data = co;
         end
         if (hs) begin
            m_res = 0; m_busy = 0; m_cnt = (m_cnt + 1) % (1 << CW); m_done++;
         end
`ifdef CONE_SIG_EN
         if (sig_clr) m_sig = '0;
         else if (cap) m_sig = ref_misr(m_sig, co);
`endif
      end
      #1;
      chk("vec_ready", 64'(vec_ready), 64'(rst_n && !m_busy));
      chk("cone_in",   64'(cone_in),   64'(m_cone));
      chk("res_valid", 64'(res_valid), 64'(m_res));
      chk("res_data",  64'(res_data),  64'(m_res_data));
      chk("vec_cnt",   64'(vec_cnt),   64'(m_cnt));
`ifdef CONE_SIG_EN
      chk("sig",       64'(sig),       64'(m_sig));
`endif
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; vec_valid = 1'b0; vec_data = '0; res_ready = 1'b0;
      force_en = 1'b0; force_val = 1'b0;
`ifdef CONE_SIG_EN
      sig_clr = 1'b0; m_sig = '0;
`endif
      m_busy = 0; m_res = 0; m_res_data = 0; m_cone = '0;
      m_acc_edge = -100; m_cnt = 0; m_done = 0; edge_n = 0;

      do_reset();
      chk("rst_vec_ready_low", 64'(vec_ready), 64'd0);
      #4;
      chk("rel_vec_ready", 64'(vec_ready), 64'd1);

      // First vector: result visible exactly S edges after accept
      vec_valid = 1'b1; vec_data = 36'h0_0000_0001;
      step();
      chk("first_cone_in", 64'(cone_in), 64'h1);
      vec_valid = 1'b0; vec_data = 36'hF_FFFF_FFFF;
      step();
      chk("first_not_yet", 64'(res_valid), 64'd0);
      step();
      chk("first_res_valid", 64'(res_valid), 64'd1);
      chk("first_res_data",  64'(res_data),  64'd1);

      // Backpressure in HOLD then release
      res_ready = 1'b0;
      repeat (5) step();
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      chk("hs_vec_cnt",   64'(vec_cnt),   64'd1);
      chk("hs_vec_ready", 64'(vec_ready), 64'd1);

      // Reset in the middle of SETTLE discards the in-flight vector
      vec_valid = 1'b1; vec_data = 36'hA_5A5A_5A5B;
      step();
      vec_valid = 1'b0;
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      repeat (3) step();
      chk("midrst_res_valid", 64'(res_valid), 64'd0);
      chk("midrst_cone_in",   64'(cone_in),   64'd0);
      chk("midrst_vec_cnt",   64'(vec_cnt),   64'd0);

`ifdef CONE_SIG_EN
      // Signature: capture 1 then 0, then clear against a coincident capture
      force_en = 1'b1; res_ready = 1'b1;
      force_val = 1'b1; vec_valid = 1'b1; step(); vec_valid = 1'b0; repeat (3) step();
      chk("sig_after_1", 64'(sig), 64'h1021);
      force_val = 1'b0; vec_valid = 1'b1; step(); vec_valid = 1'b0; repeat (3) step();
      chk("sig_after_0", 64'(sig), 64'h2042);
      force_val = 1'b1; res_ready = 1'b0; vec_valid = 1'b1; step(); vec_valid = 1'b0; step();
      sig_clr = 1'b1; step(); sig_clr = 1'b0;
      chk("sig_clr_prio", 64'(sig), 64'h0000);
      res_ready = 1'b1; step();
      force_en = 1'b0; res_ready = 1'b0;
`endif

      // Back-to-back: valid held high, counter must wrap after 2**CW results
      do_reset();
      m_done = 0; vec_valid = 1'b1; res_ready = 1'b1;
      for (int g = 0; g < 200 && m_done < 16; g++) begin
         vec_data = {4'($urandom), $urandom};
         step();
      end
      vec_valid = 1'b0;
      chk("b2b_done",    64'(m_done),  64'd16);
      chk("b2b_wrapped", 64'(vec_cnt), 64'd0);
      res_ready = 1'b0;

      // Random traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         rst_n     = ($urandom % 60) != 0;
         vec_valid = 1'($urandom);
         vec_data  = {4'($urandom), $urandom};
         res_ready = ($urandom % 3) != 0;
         force_en  = ($urandom % 8) == 0;
         force_val = 1'($urandom);
`ifdef CONE_SIG_EN
         sig_clr   = ($urandom % 25) == 0;
`endif
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
